// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle RV32I core
// Sequences fetch/decode/exec/mem/wb, arbitrates the memory port, counts retires, traps on faults.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int COUNT_W     = 32
) (
   input  logic               clk,
   input  logic               nReset,
   input  logic               run,
   input  logic [4:0]         opcode,
   input  logic               branchTaken,
   input  logic               memAck,
   output logic               memReq,
   output logic               memWe,
   output logic               memAddrSel,
   output logic               irWrite,
   output logic               regWrite,
   output logic [1:0]         wbSel,
   output logic               pcWrite,
   output logic [1:0]         pcSrc,
   output logic               retire,
   output logic [COUNT_W-1:0] instret,
   output logic               illegal,
   output logic               busErr,
   output logic               halted
);

   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   state_t     state;
   logic [7:0] wait_cnt;
   logic [4:0] lat_op;

   function automatic logic is_legal(input logic [4:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_LOAD,
         OP_STORE, OP_JAL, OP_JALR, OP_BRANCH: is_legal = 1'b1;
         default:                              is_legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         lat_op   <= '0;
         instret  <= '0;
         illegal  <= 1'b0;
         busErr   <= 1'b0;
      end else begin
         if (retire)
            instret <= instret + 1'b1;
         case (state)
            S_IDLE: begin
               if (run) begin
                  state    <= S_FETCH;
                  wait_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (memAck)
                  state <= S_DECODE;
               else if (wait_cnt == TO_LAST) begin
                  state  <= S_TRAP;
                  busErr <= 1'b1;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            S_DECODE: begin
               lat_op <= opcode;
               if (is_legal(opcode))
                  state <= S_EXEC;
               else begin
                  state   <= S_TRAP;
                  illegal <= 1'b1;
               end
            end
            S_EXEC: begin
               wait_cnt <= '0;
               if (lat_op == OP_LOAD || lat_op == OP_STORE)
                  state <= S_MEM;
               else if (lat_op == OP_BRANCH)
                  state <= S_FETCH;
               else
                  state <= S_WB;
            end
            S_MEM: begin
               if (memAck) begin
                  wait_cnt <= '0;
                  state    <= (lat_op == OP_STORE) ? S_FETCH : S_WB;
               end else if (wait_cnt == TO_LAST) begin
                  state  <= S_TRAP;
                  busErr <= 1'b1;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            S_WB: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            default: state <= S_TRAP;
         endcase
      end
   end

   // Strobes decode from the registered state; only the memAck handshake and
   // the branch compare are allowed to act within the same cycle.
   always_comb begin
      memReq     = 1'b0;
      memWe      = 1'b0;
      memAddrSel = 1'b0;
      irWrite    = 1'b0;
      regWrite   = 1'b0;
      wbSel      = 2'b00;
      pcWrite    = 1'b0;
      pcSrc      = 2'b00;
      retire     = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: begin
            memReq  = 1'b1;
            irWrite = memAck;
         end
         S_EXEC: begin
            if (lat_op == OP_BRANCH) begin
               pcWrite = 1'b1;
               pcSrc   = branchTaken ? 2'b01 : 2'b00;
               retire  = 1'b1;
            end
         end
         S_MEM: begin
            memReq     = 1'b1;
            memAddrSel = 1'b1;
            memWe      = (lat_op == OP_STORE);
            if (memAck && lat_op == OP_STORE) begin
               pcWrite = 1'b1;
               retire  = 1'b1;
            end
         end
         S_WB: begin
            regWrite = 1'b1;
            retire   = 1'b1;
            pcWrite  = 1'b1;
            if (lat_op == OP_LOAD)
               wbSel = 2'b01;
            else if (lat_op == OP_JAL || lat_op == OP_JALR)
               wbSel = 2'b10;
            if (lat_op == OP_JAL)
               pcSrc = 2'b01;
            else if (lat_op == OP_JALR)
               pcSrc = 2'b10;
         end
         S_TRAP: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
// Expected strobes come from a per-instruction phase model driven by the opcode rules.
module tb_multicycle_ctrl;

   localparam int MEM_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        nReset;
   logic        run;
   logic [4:0]  opcode;
   logic        branchTaken;
   logic        memAck;
   logic        memReq, memWe, memAddrSel, irWrite, regWrite, pcWrite, retire;
   logic [1:0]  wbSel, pcSrc;
   logic [31:0] instret;
   logic        illegal, busErr, halted;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_instret = 0;
   logic [13:0] obs;
   logic [4:0]  legal_ops [9] = '{5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b00000,
                                  5'b01000, 5'b11011, 5'b11001, 5'b11000};

   localparam logic [13:0] Z = 14'd0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_W(32)) dut (
      .clk(clk), .nReset(nReset), .run(run), .opcode(opcode),
      .branchTaken(branchTaken), .memAck(memAck), .memReq(memReq), .memWe(memWe),
      .memAddrSel(memAddrSel), .irWrite(irWrite), .regWrite(regWrite), .wbSel(wbSel),
      .pcWrite(pcWrite), .pcSrc(pcSrc), .retire(retire), .instret(instret),
      .illegal(illegal), .busErr(busErr), .halted(halted)
   );

   assign obs = {memReq, memWe, memAddrSel, irWrite, regWrite, wbSel,
                 pcWrite, pcSrc, retire, illegal, busErr, halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [13:0] mk(input logic mreq, mwe, msel, irw, rw,
                                      input logic [1:0] wb, input logic pcw,
                                      input logic [1:0] pcs, input logic ret, ill, be, hlt);
      return {mreq, mwe, msel, irw, rw, wb, pcw, pcs, ret, ill, be, hlt};
   endfunction

   function automatic logic legal(input logic [4:0] op);
      for (int k = 0; k < 9; k++)
         if (legal_ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input string tag, input logic [13:0] want);
      @(negedge clk);
      check(tag, {18'd0, obs}, {18'd0, want});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      memAck = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      nReset = 1'b1;
      run = 1'b0;
      memAck = 1'b0;
      exp_instret = 0;
      step("reset", Z);
      check("instret_rst", instret, 32'd0);
   endtask

   task automatic start();
      run = 1'b0;
      step("idle_hold", Z);
      run = 1'b1;
      step("idle_go", Z);
      run = 1'($urandom_range(0, 1));
   endtask

   task automatic trap_hold(input logic ill, input logic be);
      for (int c = 0; c < 20; c++) begin
         run = 1'($urandom_range(0, 1));
         memAck = 1'($urandom_range(0, 1));
         step("trap", mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, ill, be, 1));
      end
      check("instret_trap", instret, exp_instret);
      do_reset();
      start();
   endtask

   // One memory handshake: wt wait cycles then ack; wt >= MEM_TIMEOUT never acks.
   task automatic mem_phase(input string tag, input logic sel, input logic we,
                            input logic st_ret, input int wt, output bit tr);
      tr = 1'b0;
      for (int i = 0; i <= wt; i++) begin
         if (i == MEM_TIMEOUT) begin
            tr = 1'b1;
            break;
         end
         memAck = (i == wt);
         step(tag, mk(1, we, sel, !sel && (i == wt), 0, 2'b00, st_ret && (i == wt),
                      2'b00, st_ret && (i == wt), 0, 0, 0));
         if (st_ret && i == wt) exp_instret++;
      end
      memAck = 1'b0;
   endtask

   task automatic exec_instr(input logic [4:0] op, input logic bt, input int fw, input int mw);
      bit tr;
      logic ld, st, br, jal, jalr;
      logic [1:0] wb, pcs;
      ld = (op == 5'b00000);
      st = (op == 5'b01000);
      br = (op == 5'b11000);
      jal = (op == 5'b11011);
      jalr = (op == 5'b11001);
      check("instret", instret, exp_instret);
      mem_phase("fetch", 1'b0, 1'b0, 1'b0, fw, tr);
      if (tr) begin
         trap_hold(1'b0, 1'b1);
         return;
      end
      opcode = op;
      memAck = 1'($urandom_range(0, 1));
      step("decode", Z);
      if (!legal(op)) begin
         trap_hold(1'b1, 1'b0);
         return;
      end
      branchTaken = bt;
      memAck = 1'($urandom_range(0, 1));
      if (br) begin
         step("exec_br", mk(0, 0, 0, 0, 0, 2'b00, 1, bt ? 2'b01 : 2'b00, 1, 0, 0, 0));
         exp_instret++;
         memAck = 1'b0;
         return;
      end
      step("exec", Z);
      memAck = 1'b0;
      if (ld || st) begin
         mem_phase("mem", 1'b1, st, st, mw, tr);
         if (tr) begin
            trap_hold(1'b0, 1'b1);
            return;
         end
         if (st) return;
      end
      wb = ld ? 2'b01 : ((jal || jalr) ? 2'b10 : 2'b00);
      pcs = jal ? 2'b01 : (jalr ? 2'b10 : 2'b00);
      memAck = 1'($urandom_range(0, 1));
      step("wb", mk(0, 0, 0, 0, 1, wb, 1, pcs, 1, 0, 0, 0));
      exp_instret++;
      memAck = 1'b0;
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0) return MEM_TIMEOUT;
      if (r == 1) return MEM_TIMEOUT - 1;
      return int'($urandom_range(0, 3));
   endfunction

   initial begin
      nReset = 1'b0;
      run = 1'b0;
      opcode = 5'd0;
      branchTaken = 1'b0;
      memAck = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      start();

      exec_instr(5'b01100, 1'b0, 0, 0);
      check("instret_first", instret, 32'd1);
      exec_instr(5'b00000, 1'b0, 0, 3);
      exec_instr(5'b11000, 1'b1, 0, 0);
      exec_instr(5'b11000, 1'b0, 0, 0);
      exec_instr(5'b11001, 1'b0, 0, 0);
      exec_instr(5'b01000, 1'b0, 0, 0);
      exec_instr(5'b01100, 1'b0, MEM_TIMEOUT - 1, 0);
      exec_instr(5'b11111, 1'b0, 0, 0);
      exec_instr(5'b01100, 1'b0, MEM_TIMEOUT, 0);
      exec_instr(5'b00000, 1'b0, 0, MEM_TIMEOUT);

      for (int c = 0; c < 3; c++) begin
         memAck = 1'b0;
         step("fetch_wait", mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
      end
      do_reset();
      start();

      for (int n = 0; n < 300; n++) begin
         logic [4:0] op;
         if ($urandom_range(0, 11) == 0)
            op = 5'($urandom_range(0, 31));
         else
            op = legal_ops[$urandom_range(0, 8)];
         exec_instr(op, 1'($urandom_range(0, 1)), pick_wait(), pick_wait());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
